// File: rtl/button_debounce_multi_pkg.sv
// Shared types and elaboration helpers for the multi-button debouncer.
// Holds the per-channel FSM encoding and the counter width helpers.
package button_debounce_multi_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } btn_state_t;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One button: 2-flop synchroniser, stable-level filter and auto-repeat FSM.
// The FSM state is held in 'state' so checkers can observe it hierarchically.
module debounce_channel
  import button_debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic press_next,
  output logic release_pulse
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
  localparam int RW = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

  logic          s1;
  logic          s2;
  logic          raw;
  logic          differ;
  logic          accept_press;
  logic          accept_release;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic          rep_fire;
  btn_state_t    state;
  btn_state_t    state_next;

  // raw is 1 when the synchronised pin reads "pressed".
  assign raw            = s2 ^ PIN_IDLE;
  assign differ         = (raw != level);
  assign accept_press   = differ && (dcnt == D_LAST) && raw;
  assign accept_release = differ && (dcnt == D_LAST) && !raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= PIN_IDLE;
      s2    <= PIN_IDLE;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (!differ) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        level <= raw;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rep_fire   = 1'b0;
    case (state)
      RELEASED: begin
        if (accept_press) begin
          state_next = HELD_DELAY;
          rcnt_next  = '0;
        end
      end
      HELD_DELAY: begin
        if (!repeat_en) begin
          rcnt_next = '0;
        end else if (rcnt == DELAY_LAST) begin
          rep_fire   = 1'b1;
          rcnt_next  = '0;
          state_next = HELD_REPEAT;
        end else begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      HELD_REPEAT: begin
        if (!repeat_en) begin
          rcnt_next  = '0;
          state_next = HELD_DELAY;
        end else if (rcnt == PERIOD_LAST) begin
          rep_fire  = 1'b1;
          rcnt_next = '0;
        end else begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        rcnt_next  = '0;
      end
    endcase
    // A release accepted on the same cycle a repeat falls due suppresses it.
    if (accept_release && (state != RELEASED)) begin
      state_next = RELEASED;
      rcnt_next  = '0;
      rep_fire   = 1'b0;
    end
  end

  assign press_next = accept_press | rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= press_next;
      release_pulse <= accept_release;
    end
  end

endmodule

// File: rtl/button_debounce_multi.sv
// N_BTN independent debounced buttons with press/release pulses and auto-repeat.
// 'release' is a reserved word in SystemVerilog, so that output is release_pulse.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic             press_any
);

  logic [N_BTN-1:0] press_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn_in[i]),
      .repeat_en    (repeat_en),
      .level        (level[i]),
      .press        (press[i]),
      .press_next   (press_next[i]),
      .release_pulse(release_pulse[i])
    );
  end

  // Registered from the same next-press terms so it lines up with press.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_any <= 1'b0;
    end else begin
      press_any <= |press_next;
    end
  end

endmodule
